// File: rtl/rx_data_sampler.sv
// UART RX oversampling front-end: 2-flop synchroniser, per-bit edge counter, 3-sample
// mid-bit majority vote. Optional SAMP_GLITCH_FLAG_EN adds samp_glitch (samples disagreed).
module rx_data_sampler #(
  parameter int PRESC_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic               dat_samp_en,
  input  logic [PRESC_W-1:0] Prescale,
`ifdef SAMP_GLITCH_FLAG_EN
  output logic               samp_glitch,
`endif
  output logic               sampled_bit,
  output logic               finish_s,
  output logic               bit_tick,
  output logic [PRESC_W-1:0] edge_cnt
);

  localparam logic [PRESC_W-1:0] P_MIN = PRESC_W'(8);
  localparam logic [PRESC_W-1:0] ONE   = PRESC_W'(1);

  // Ratio must be even and at least 8 so the three samples and the vote fit before the last edge.
  function automatic logic [PRESC_W-1:0] clean_presc(input logic [PRESC_W-1:0] p);
    logic [PRESC_W-1:0] even;
    even = {p[PRESC_W-1:1], 1'b0};
    return (even < P_MIN) ? P_MIN : even;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic               sync1_q, sync2_q;
  logic               en_prev_q;
  logic [PRESC_W-1:0] p_q, p_d;
  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic [1:0]         samp_q, samp_d;
  logic               sampled_q, sampled_d;
  logic               finish_q, finish_d;
  logic               tick_q, tick_d;
  logic [PRESC_W-1:0] half, last;
  logic               en_rise;
`ifdef SAMP_GLITCH_FLAG_EN
  logic               glitch_q, glitch_d;
`endif

  always_comb begin
    en_rise   = dat_samp_en & ~en_prev_q;
    p_d       = en_rise ? clean_presc(Prescale) : p_q;
    half      = p_d >> 1;
    last      = p_d - ONE;
    cnt_d     = '0;
    samp_d    = samp_q;
    sampled_d = sampled_q;
    finish_d  = 1'b0;
    tick_d    = 1'b0;
`ifdef SAMP_GLITCH_FLAG_EN
    glitch_d  = 1'b0;
`endif
    if (dat_samp_en) begin
      cnt_d = (cnt_q == last) ? '0 : cnt_q + ONE;
      if (cnt_q == half - ONE) samp_d[0] = sync2_q;
      if (cnt_q == half)       samp_d[1] = sync2_q;
      // Third sample is the live synchronised line; the vote lands as edge_cnt reaches H+2.
      if (cnt_q == half + ONE) begin
        sampled_d = majority3(samp_q[0], samp_q[1], sync2_q);
        finish_d  = 1'b1;
`ifdef SAMP_GLITCH_FLAG_EN
        glitch_d  = ~((samp_q[0] == samp_q[1]) && (samp_q[1] == sync2_q));
`endif
      end
      tick_d = (cnt_d == last);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      en_prev_q <= 1'b0;
      p_q       <= P_MIN;
      cnt_q     <= '0;
      samp_q    <= 2'b11;
      sampled_q <= 1'b1;
      finish_q  <= 1'b0;
      tick_q    <= 1'b0;
`ifdef SAMP_GLITCH_FLAG_EN
      glitch_q  <= 1'b0;
`endif
    end else begin
      sync1_q   <= RX_IN;
      sync2_q   <= sync1_q;
      en_prev_q <= dat_samp_en;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      samp_q    <= samp_d;
      sampled_q <= sampled_d;
      finish_q  <= finish_d;
      tick_q    <= tick_d;
`ifdef SAMP_GLITCH_FLAG_EN
      glitch_q  <= glitch_d;
`endif
    end
  end

  assign sampled_bit = sampled_q;
  assign finish_s    = finish_q;
  assign bit_tick    = tick_q;
  assign edge_cnt    = cnt_q;
`ifdef SAMP_GLITCH_FLAG_EN
  assign samp_glitch = glitch_q;
`endif

endmodule

// File: tb/tb_rx_data_sampler.sv
// Directed-vector bench for rx_data_sampler; define SAMP_GLITCH_FLAG_EN to also check samp_glitch.
module tb_rx_data_sampler;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic       dat_samp_en;
  logic [5:0] Prescale;
  logic       sampled_bit, finish_s, bit_tick;
  logic [5:0] edge_cnt;
`ifdef SAMP_GLITCH_FLAG_EN
  logic       samp_glitch;
`endif

  int checks = 0;
  int errors = 0;
  int ticks;
  logic [0:9] fr;

  rx_data_sampler #(.PRESC_W(6)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .dat_samp_en(dat_samp_en), .Prescale(Prescale),
`ifdef SAMP_GLITCH_FLAG_EN
    .samp_glitch(samp_glitch),
`endif
    .sampled_bit(sampled_bit), .finish_s(finish_s), .bit_tick(bit_tick), .edge_cnt(edge_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_glitch(input string tag, input int exp);
`ifdef SAMP_GLITCH_FLAG_EN
    chk(tag, int'(samp_glitch), exp);
`endif
  endtask

  initial begin
    RST = 1'b0; dat_samp_en = 1'b0; RX_IN = 1'b1; Prescale = 6'd8;
    step(); step();
    chk("rst_sampled", int'(sampled_bit), 1);
    chk("rst_finish", int'(finish_s), 0);
    chk("rst_tick", int'(bit_tick), 0);
    chk("rst_cnt", int'(edge_cnt), 0);
    chk_glitch("rst_glitch", 0);
    RST = 1'b1;

    // T1: P=8, line held low
    RX_IN = 1'b0;
    repeat (3) step();
    dat_samp_en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("t1_cnt", int'(edge_cnt), k % 8);
      chk("t1_finish", int'(finish_s), int'(k % 8 == 6));
      chk("t1_tick", int'(bit_tick), int'(k % 8 == 7));
      chk_glitch("t1_glitch", 0);
      if (k % 8 == 6) chk("t1_sampled", int'(sampled_bit), 0);
    end
    dat_samp_en = 1'b0;
    step();
    chk("t1_off_cnt", int'(edge_cnt), 0);
    chk("t1_off_finish", int'(finish_s), 0);

    // T2: P=16, single-cycle glitch on s1 then two-cycle glitch on s0/s1
    Prescale = 6'd16; RX_IN = 1'b1;
    repeat (3) step();
    dat_samp_en = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      step();
      chk("t2_cnt", int'(edge_cnt), k % 16);
      chk("t2_finish", int'(finish_s), int'(k % 16 == 10));
      chk("t2_tick", int'(bit_tick), int'(k % 16 == 15));
      chk_glitch("t2_glitch", int'(k == 10 || k == 26));
      if (k == 10) chk("t2_sampled_b0", int'(sampled_bit), 1);
      if (k == 26) chk("t2_sampled_b1", int'(sampled_bit), 0);
      RX_IN = (k == 6 || k == 21 || k == 22) ? 1'b0 : 1'b1;
    end
    dat_samp_en = 1'b0; RX_IN = 1'b1;
    repeat (2) step();

    // T3: P=32, frame 0_10110010_1
    fr = 10'b0101100101;
    Prescale = 6'd32;
    repeat (2) step();
    ticks = 0;
    dat_samp_en = 1'b1; RX_IN = fr[0];
    for (int k = 1; k <= 320; k++) begin
      step();
      chk("t3_cnt", int'(edge_cnt), k % 32);
      chk("t3_finish", int'(finish_s), int'(k % 32 == 18));
      chk("t3_tick", int'(bit_tick), int'(k % 32 == 31));
      if (bit_tick) ticks++;
      if (k % 32 == 18) chk("t3_bit", int'(sampled_bit), int'(fr[k / 32]));
      if (k < 320) RX_IN = fr[k / 32];
    end
    chk("t3_tick_count", ticks, 10);
    dat_samp_en = 1'b0; RX_IN = 1'b1;

    // T4: Prescale change while enabled is ignored until re-enable
    Prescale = 6'd16;
    repeat (3) step();
    dat_samp_en = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      chk("t4_cnt16", int'(edge_cnt), k % 16);
      chk("t4_finish16", int'(finish_s), int'(k % 16 == 10));
      chk("t4_tick16", int'(bit_tick), int'(k % 16 == 15));
      if (k == 5) Prescale = 6'd8;
    end
    dat_samp_en = 1'b0;
    step();
    chk("t4_off_cnt", int'(edge_cnt), 0);
    dat_samp_en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("t4_cnt8", int'(edge_cnt), k % 8);
      chk("t4_finish8", int'(finish_s), int'(k % 8 == 6));
      chk("t4_tick8", int'(bit_tick), int'(k % 8 == 7));
      if (k % 8 == 6) chk("t4_sampled", int'(sampled_bit), 1);
    end

    // T5: enable dropped at edge_cnt=H discards the pending vote
    dat_samp_en = 1'b0; Prescale = 6'd16; RX_IN = 1'b0;
    repeat (3) step();
    dat_samp_en = 1'b1;
    repeat (8) step();
    chk("t5_cnt_at_h", int'(edge_cnt), 8);
    dat_samp_en = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("t5_cnt", int'(edge_cnt), 0);
      chk("t5_finish", int'(finish_s), 0);
      chk("t5_tick", int'(bit_tick), 0);
      chk("t5_sampled", int'(sampled_bit), 1);
    end

    // T6: reset at edge_cnt=H+1, then Prescale=5 behaves as 8
    dat_samp_en = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      step();
      chk("t6_cnt", int'(edge_cnt), k % 16);
      if (k == 10) begin
        chk("t6_finish_b0", int'(finish_s), 1);
        chk("t6_sampled_b0", int'(sampled_bit), 0);
      end
    end
    RST = 1'b0;
    step();
    chk("t6_rst_cnt", int'(edge_cnt), 0);
    chk("t6_rst_finish", int'(finish_s), 0);
    chk("t6_rst_tick", int'(bit_tick), 0);
    chk("t6_rst_sampled", int'(sampled_bit), 1);
    chk_glitch("t6_rst_glitch", 0);
    RST = 1'b1; Prescale = 6'd5;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("t6_cnt8", int'(edge_cnt), k % 8);
      chk("t6_finish8", int'(finish_s), int'(k % 8 == 6));
      chk("t6_tick8", int'(bit_tick), int'(k % 8 == 7));
      if (k % 8 == 6) chk("t6_sampled8", int'(sampled_bit), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
